// File: rtl/spu_issue_pkg.sv
// Shared types and helpers for the SPU dual-issue stage.
// - fmt_t      : instruction format code carried alongside each word
// - NOP_EVEN/NOP_ODD : filler words driven on an idle pipe
// - src_mask   : which source fields {ra, rb, rc} a format reads
// - dest_field : destination register field for a format
// Instruction words use big-endian bit numbering [0:31].
package spu_issue_pkg;

  typedef enum logic [2:0] {
    FMT_RR    = 3'd0,
    FMT_RRR   = 3'd1,
    FMT_RI7   = 3'd2,
    FMT_RI10  = 3'd3,
    FMT_RI16  = 3'd4,
    FMT_RI18  = 3'd5,
    FMT_STORE = 3'd6,
    FMT_NOP   = 3'd7
  } fmt_t;

  localparam logic [0:31] NOP_EVEN = 32'h4020_0000;
  localparam logic [0:31] NOP_ODD  = 32'h0020_0000;

  // Bit 2 = ra [18:24], bit 1 = rb [11:17], bit 0 = rc/rt_src [25:31].
  function automatic logic [2:0] src_mask(fmt_t fmt);
    logic [2:0] m;
    m = 3'b000;
    unique case (fmt)
      FMT_RR:              m = 3'b110;
      FMT_RRR:             m = 3'b111;
      FMT_RI7, FMT_RI10:   m = 3'b100;
      FMT_STORE:           m = 3'b101;
      FMT_RI16, FMT_RI18,
      FMT_NOP:             m = 3'b000;
      default:             m = 3'b000;
    endcase
    return m;
  endfunction

  // RRR keeps its target in [4:10] because [25:31] is the third source.
  function automatic logic [6:0] dest_field(logic [0:31] instr, fmt_t fmt);
    return (fmt == FMT_RRR) ? instr[4:10] : instr[25:31];
  endfunction

endpackage

// File: rtl/spu_scoreboard.sv
// Per-register latency scoreboard.
// - set_en/set_addr/set_lat : two set ports, one per issuing slot
// - rd_addr/rd_zero         : NRD read ports, rd_zero=1 when the counter is 0
// Every nonzero counter counts down by one each cycle; a set on the same
// edge overrides the decrement for that register.
module spu_scoreboard
  import spu_issue_pkg::*;
#(
  parameter int unsigned NREGS = 128,
  parameter int unsigned LATW  = 4,
  parameter int unsigned NRD   = 8,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      set_en,
  input  logic [AW-1:0]   set_addr [2],
  input  logic [LATW-1:0] set_lat  [2],
  input  logic [AW-1:0]   rd_addr  [NRD],
  output logic [NRD-1:0]  rd_zero
);

  logic [LATW-1:0] cnt_q [NREGS];
  logic [LATW-1:0] cnt_d [NREGS];

  always_comb begin
    for (int r = 0; r < int'(NREGS); r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - 1'b1 : '0;
    end
    for (int s = 0; s < 2; s++) begin
      if (set_en[s]) cnt_d[set_addr[s]] = set_lat[s];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < int'(NREGS); r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < int'(NREGS); r++) cnt_q[r] <= cnt_d[r];
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NRD); i++) rd_zero[i] = (cnt_q[rd_addr[i]] == '0);
  end

endmodule

// File: rtl/spu_dual_issue.sv
// SPU dual-issue stage: 2-entry in-order buffer, pipe routing and
// scoreboard-based RAW/WAW interlock.
// - pair_valid/pair_ready + instr/pipe/fmt/wr/lat _a/_b : incoming pair (a older)
// - stall : hold outputs and buffer; flush : drop buffer, outputs go to NOP
// - *_even/*_odd : registered issue bundle for each pipe
// Buffer slot 0 is the head (older), slot 1 the next instruction.
module spu_dual_issue
  import spu_issue_pkg::*;
#(
  parameter int unsigned NREGS = 128,
  parameter int unsigned LATW  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pair_valid,
  output logic            pair_ready,
  input  logic [0:31]     instr_a,
  input  logic [0:31]     instr_b,
  input  logic            pipe_a,
  input  logic            pipe_b,
  input  fmt_t            fmt_a,
  input  fmt_t            fmt_b,
  input  logic            wr_a,
  input  logic            wr_b,
  input  logic [LATW-1:0] lat_a,
  input  logic [LATW-1:0] lat_b,
  input  logic            stall,
  input  logic            flush,
  output logic [0:31]     instr_even,
  output logic [0:31]     instr_odd,
  output fmt_t            format_even,
  output fmt_t            format_odd,
  output logic [6:0]      rt_addr_even,
  output logic [6:0]      rt_addr_odd,
  output logic            reg_write_even,
  output logic            reg_write_odd,
  output logic            valid_even,
  output logic            valid_odd
);

  localparam int unsigned NRD = 8;  // per slot: ra, rb, rc, destination

  logic [1:0]      v_q, v_d, pipe_q, pipe_d, wr_q, wr_d;
  logic [0:31]     instr_q [2];
  logic [0:31]     instr_d [2];
  fmt_t            fmt_q [2];
  fmt_t            fmt_d [2];
  logic [LATW-1:0] lat_q [2];
  logic [LATW-1:0] lat_d [2];

  logic [6:0]      ra [2];
  logic [6:0]      rb [2];
  logic [6:0]      rc [2];
  logic [6:0]      dst [2];
  logic [2:0]      msk [2];
  logic [6:0]      rd_addr [NRD];
  logic [NRD-1:0]  rd_zero;
  logic [1:0]      rdy, iss;
  logic            issue_head, issue_next, raw_dep, waw_dep;

  always_comb begin
    for (int e = 0; e < 2; e++) begin
      ra[e]  = instr_q[e][18:24];
      rb[e]  = instr_q[e][11:17];
      rc[e]  = instr_q[e][25:31];
      dst[e] = dest_field(instr_q[e], fmt_q[e]);
      msk[e] = src_mask(fmt_q[e]);
      rd_addr[4*e]   = ra[e];
      rd_addr[4*e+1] = rb[e];
      rd_addr[4*e+2] = rc[e];
      rd_addr[4*e+3] = dst[e];
    end
  end

  always_comb begin
    for (int e = 0; e < 2; e++) begin
      rdy[e] = v_q[e] & (~msk[e][2] | rd_zero[4*e]) & (~msk[e][1] | rd_zero[4*e+1]) &
               (~msk[e][0] | rd_zero[4*e+2]) & (~wr_q[e] | rd_zero[4*e+3]);
    end
    // Head's counter is not yet set while both are evaluated, so same-cycle
    // dependencies on head's rt must be caught here.
    raw_dep = wr_q[0] & ((msk[1][2] & (ra[1] == dst[0])) | (msk[1][1] & (rb[1] == dst[0])) |
                         (msk[1][0] & (rc[1] == dst[0])));
    waw_dep = wr_q[0] & wr_q[1] & (dst[1] == dst[0]);
  end

  assign issue_head = ~stall & ~flush & rdy[0];
  assign issue_next = issue_head & rdy[1] & (pipe_q[1] != pipe_q[0]) & ~raw_dep & ~waw_dep;
  assign iss        = {issue_next, issue_head};
  assign pair_ready = ~v_q[0] & ~v_q[1] & ~flush;

  logic [1:0]      set_en;
  logic [6:0]      set_addr [2];
  logic [LATW-1:0] set_lat  [2];

  always_comb begin
    for (int e = 0; e < 2; e++) begin
      set_en[e]   = iss[e] & wr_q[e];
      set_addr[e] = dst[e];
      set_lat[e]  = lat_q[e];
    end
  end

  spu_scoreboard #(
    .NREGS (NREGS),
    .LATW  (LATW),
    .NRD   (NRD),
    .AW    (7)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .set_en   (set_en),
    .set_addr (set_addr),
    .set_lat  (set_lat),
    .rd_addr  (rd_addr),
    .rd_zero  (rd_zero)
  );

  // Buffer next state. All-zero words are dropped on load.
  always_comb begin
    v_d    = v_q;
    pipe_d = pipe_q;
    wr_d   = wr_q;
    for (int e = 0; e < 2; e++) begin
      instr_d[e] = instr_q[e];
      fmt_d[e]   = fmt_q[e];
      lat_d[e]   = lat_q[e];
    end
    if (flush || issue_next) begin
      v_d = 2'b00;
    end else if (issue_head) begin
      v_d        = {1'b0, v_q[1]};
      instr_d[0] = instr_q[1];
      fmt_d[0]   = fmt_q[1];
      lat_d[0]   = lat_q[1];
      pipe_d[0]  = pipe_q[1];
      wr_d[0]    = wr_q[1];
    end
    if (pair_ready && pair_valid) begin
      if (instr_a != '0) begin
        v_d        = {instr_b != '0, 1'b1};
        instr_d[0] = instr_a;
        fmt_d[0]   = fmt_a;
        lat_d[0]   = lat_a;
        pipe_d[0]  = pipe_a;
        wr_d[0]    = wr_a;
        instr_d[1] = instr_b;
        fmt_d[1]   = fmt_b;
        lat_d[1]   = lat_b;
        pipe_d[1]  = pipe_b;
        wr_d[1]    = wr_b;
      end else begin
        v_d        = {1'b0, instr_b != '0};
        instr_d[0] = instr_b;
        fmt_d[0]   = fmt_b;
        lat_d[0]   = lat_b;
        pipe_d[0]  = pipe_b;
        wr_d[0]    = wr_b;
      end
    end
  end

  logic [0:31] ie_q, ie_d, io_q, io_d;
  fmt_t        fe_q, fe_d, fo_q, fo_d;
  logic [6:0]  re_q, re_d, ro_q, ro_d;
  logic        we_q, we_d, wo_q, wo_d, ve_q, ve_d, vo_q, vo_d;

  always_comb begin
    ie_d = ie_q; io_d = io_q; fe_d = fe_q; fo_d = fo_q;
    re_d = re_q; ro_d = ro_q; we_d = we_q; wo_d = wo_q; ve_d = ve_q; vo_d = vo_q;
    if (flush || !stall) begin
      ie_d = NOP_EVEN; fe_d = FMT_NOP; re_d = '0; we_d = 1'b0; ve_d = 1'b0;
      io_d = NOP_ODD;  fo_d = FMT_NOP; ro_d = '0; wo_d = 1'b0; vo_d = 1'b0;
    end
    for (int e = 0; e < 2; e++) begin
      if (iss[e]) begin
        if (pipe_q[e]) begin
          io_d = instr_q[e]; fo_d = fmt_q[e]; ro_d = dst[e]; wo_d = wr_q[e]; vo_d = 1'b1;
        end else begin
          ie_d = instr_q[e]; fe_d = fmt_q[e]; re_d = dst[e]; we_d = wr_q[e]; ve_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q    <= '0;
      pipe_q <= '0;
      wr_q   <= '0;
      for (int e = 0; e < 2; e++) begin
        instr_q[e] <= '0;
        fmt_q[e]   <= FMT_NOP;
        lat_q[e]   <= '0;
      end
      ie_q <= NOP_EVEN; io_q <= NOP_ODD; fe_q <= FMT_NOP; fo_q <= FMT_NOP;
      re_q <= '0; ro_q <= '0; we_q <= 1'b0; wo_q <= 1'b0; ve_q <= 1'b0; vo_q <= 1'b0;
    end else begin
      v_q    <= v_d;
      pipe_q <= pipe_d;
      wr_q   <= wr_d;
      for (int e = 0; e < 2; e++) begin
        instr_q[e] <= instr_d[e];
        fmt_q[e]   <= fmt_d[e];
        lat_q[e]   <= lat_d[e];
      end
      ie_q <= ie_d; io_q <= io_d; fe_q <= fe_d; fo_q <= fo_d;
      re_q <= re_d; ro_q <= ro_d; we_q <= we_d; wo_q <= wo_d; ve_q <= ve_d; vo_q <= vo_d;
    end
  end

  assign instr_even     = ie_q;
  assign instr_odd      = io_q;
  assign format_even    = fe_q;
  assign format_odd     = fo_q;
  assign rt_addr_even   = re_q;
  assign rt_addr_odd    = ro_q;
  assign reg_write_even = we_q;
  assign reg_write_odd  = wo_q;
  assign valid_even     = ve_q;
  assign valid_odd      = vo_q;

endmodule

// File: tb/tb_spu_dual_issue.sv
// Self-checking bench for spu_dual_issue: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// queue-and-counter-array model of the issue rules.
module tb_spu_dual_issue;
  import spu_issue_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        pair_valid, pair_ready;
  logic [31:0] instr_a, instr_b;
  logic        pipe_a, pipe_b, wr_a, wr_b, stall, flush;
  fmt_t        fmt_a, fmt_b;
  logic [3:0]  lat_a, lat_b;
  logic [31:0] instr_even, instr_odd;
  fmt_t        format_even, format_odd;
  logic [6:0]  rt_addr_even, rt_addr_odd;
  logic        reg_write_even, reg_write_odd, valid_even, valid_odd;

  always #5 clk = ~clk;

  spu_dual_issue #(.NREGS(128), .LATW(4)) dut (
    .clk(clk), .reset(reset), .pair_valid(pair_valid), .pair_ready(pair_ready),
    .instr_a(instr_a), .instr_b(instr_b), .pipe_a(pipe_a), .pipe_b(pipe_b),
    .fmt_a(fmt_a), .fmt_b(fmt_b), .wr_a(wr_a), .wr_b(wr_b), .lat_a(lat_a), .lat_b(lat_b),
    .stall(stall), .flush(flush), .instr_even(instr_even), .instr_odd(instr_odd),
    .format_even(format_even), .format_odd(format_odd), .rt_addr_even(rt_addr_even),
    .rt_addr_odd(rt_addr_odd), .reg_write_even(reg_write_even),
    .reg_write_odd(reg_write_odd), .valid_even(valid_even), .valid_odd(valid_odd)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] w;
    logic        pipe;
    int          fmt;
    logic        wr;
    int          lat;
  } ins_t;

  ins_t q[$];
  int   cnt[128];
  logic [31:0] e_ie, e_io;
  int   e_fe, e_fo, e_re, e_ro;
  bit   e_we, e_wo, e_ve, e_vo;

  // Field k: 0 = ra [18:24], 1 = rb [11:17], 2 = rc [25:31] (bit 0 is the MSB).
  function automatic int fld(logic [31:0] w, int k);
    int sh;
    sh = (k == 0) ? 7 : (k == 1) ? 14 : 0;
    return int'((w >> sh) & 32'h7f);
  endfunction

  function automatic int dst(ins_t e);
    return (e.fmt == 1) ? int'((e.w >> 21) & 32'h7f) : fld(e.w, 2);
  endfunction

  function automatic bit uses(ins_t e, int k);
    case (e.fmt)
      0:       return k != 2;
      1:       return 1'b1;
      2, 3:    return k == 0;
      6:       return k != 1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit reads(ins_t e, int r);
    for (int k = 0; k < 3; k++) if (uses(e, k) && fld(e.w, k) == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit can_go(ins_t e);
    for (int k = 0; k < 3; k++) if (uses(e, k) && cnt[fld(e.w, k)] != 0) return 1'b0;
    if (e.wr && cnt[dst(e)] != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void nop_outs();
    e_ie = NOP_EVEN; e_io = NOP_ODD; e_fe = 7; e_fo = 7;
    e_re = 0; e_ro = 0; e_we = 0; e_wo = 0; e_ve = 0; e_vo = 0;
  endfunction

  function automatic void model_reset();
    q.delete();
    foreach (cnt[r]) cnt[r] = 0;
    nop_outs();
  endfunction

  function automatic void place(ins_t e);
    if (e.pipe) begin
      e_io = e.w; e_fo = e.fmt; e_ro = dst(e); e_wo = e.wr; e_vo = 1;
    end else begin
      e_ie = e.w; e_fe = e.fmt; e_re = dst(e); e_we = e.wr; e_ve = 1;
    end
  endfunction

  // drive values for the next cycle
  logic        d_rst, d_pv, d_pa, d_pb, d_wa, d_wb, d_stall, d_flush;
  logic [31:0] d_ia, d_ib;
  fmt_t        d_fa, d_fb;
  logic [3:0]  d_la, d_lb;

  function automatic void model_step();
    bit hi, ni;
    ins_t h, n;
    int pre;
    if (d_rst) begin
      model_reset();
      return;
    end
    pre = q.size();
    hi = 0; ni = 0;
    if (!d_stall && !d_flush && pre > 0 && can_go(q[0])) begin
      hi = 1; h = q[0];
      if (pre > 1) begin
        n  = q[1];
        ni = can_go(n) && (n.pipe != h.pipe) && !(h.wr && reads(n, dst(h))) &&
             !(h.wr && n.wr && dst(h) == dst(n));
      end
    end
    foreach (cnt[r]) if (cnt[r] > 0) cnt[r]--;
    if (hi && h.wr) cnt[dst(h)] = h.lat;
    if (ni && n.wr) cnt[dst(n)] = n.lat;
    if (d_flush) nop_outs();
    else if (!d_stall) begin
      nop_outs();
      if (hi) place(h);
      if (ni) place(n);
    end
    if (d_flush) q.delete();
    else begin
      if (hi) void'(q.pop_front());
      if (ni) void'(q.pop_front());
    end
    if (pre == 0 && !d_flush && d_pv) begin
      if (d_ia != 0) q.push_back('{w: d_ia, pipe: d_pa, fmt: int'(d_fa), wr: d_wa, lat: int'(d_la)});
      if (d_ib != 0) q.push_back('{w: d_ib, pipe: d_pb, fmt: int'(d_fb), wr: d_wb, lat: int'(d_lb)});
    end
  endfunction

  task automatic cmp_outputs();
    chk("instr_even", instr_even, e_ie);
    chk("instr_odd", instr_odd, e_io);
    chk("format_even", format_even, e_fe);
    chk("format_odd", format_odd, e_fo);
    chk("rt_addr_even", rt_addr_even, e_re);
    chk("rt_addr_odd", rt_addr_odd, e_ro);
    chk("reg_write_even", reg_write_even, e_we);
    chk("reg_write_odd", reg_write_odd, e_wo);
    chk("valid_even", valid_even, e_ve);
    chk("valid_odd", valid_odd, e_vo);
  endtask

  // One cycle: compare registered outputs, drive inputs, check pair_ready, advance model.
  task automatic step();
    @(negedge clk);
    cmp_outputs();
    reset = d_rst; pair_valid = d_pv; stall = d_stall; flush = d_flush;
    instr_a = d_ia; instr_b = d_ib; pipe_a = d_pa; pipe_b = d_pb;
    fmt_a = d_fa; fmt_b = d_fb; wr_a = d_wa; wr_b = d_wb; lat_a = d_la; lat_b = d_lb;
    #1;
    if (!d_rst) chk("pair_ready", pair_ready, (q.size() == 0) && !d_flush);
    model_step();
  endtask

  task automatic idle(int n);
    d_pv = 0; d_stall = 0; d_flush = 0;
    repeat (n) step();
  endtask

  function automatic logic [31:0] mkw(int fmt, int rt, int ra, int rb, int rc);
    logic [31:0] w;
    w = 32'h8000_0000 | (32'(ra & 127) << 7) | (32'(rb & 127) << 14);
    if (fmt == 1) w = w | (32'(rt & 127) << 21) | 32'(rc & 127);
    else          w = w | 32'(rt & 127);
    return w;
  endfunction

  task automatic put_pair(logic [31:0] wa, logic pa, fmt_t fa, logic wra, int la,
                          logic [31:0] wb, logic pb, fmt_t fb, logic wrb, int lb);
    d_ia = wa; d_pa = pa; d_fa = fa; d_wa = wra; d_la = 4'(la);
    d_ib = wb; d_pb = pb; d_fb = fb; d_wb = wrb; d_lb = 4'(lb);
    d_pv = 1;
    step();
    d_pv = 0;
  endtask

  task automatic rand_ins(output logic [31:0] w, output logic p, output fmt_t f,
                          output logic wr, output logic [3:0] lat);
    int fm;
    fm  = $urandom_range(0, 7);
    f   = fmt_t'(3'(fm));
    w   = mkw(fm, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 7)) | ($urandom & 32'h7000_0000);
    if ($urandom_range(0, 11) == 0) w = 32'h0;
    p   = 1'($urandom_range(0, 1));
    wr  = (fm == 6) ? 1'b0 : 1'($urandom_range(0, 1));
    lat = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(1, 6));
  endtask

  logic [31:0] wa, wb;

  initial begin
    reset = 1'b1;
    d_rst = 1; d_pv = 0; d_stall = 0; d_flush = 0;
    d_ia = 0; d_ib = 0; d_pa = 0; d_pb = 0; d_wa = 0; d_wb = 0;
    d_fa = FMT_NOP; d_fb = FMT_NOP; d_la = 0; d_lb = 0;
    model_reset();
    idle(3);
    d_rst = 0;
    idle(2);

    // Reset mid-stream while counter[5] is pending.
    wa = mkw(4, 5, 0, 0, 0);
    put_pair(wa, 0, FMT_RI16, 1, 3, mkw(7, 0, 0, 0, 0), 1, FMT_NOP, 0, 1);
    repeat (2) step();
    chk("rst_pre_valid_even", valid_even, 1);
    chk("rst_pre_rt_even", rt_addr_even, 5);
    reset = 1'b1;
    #1;
    chk("rst_instr_even", instr_even, NOP_EVEN);
    chk("rst_instr_odd", instr_odd, NOP_ODD);
    chk("rst_valid_even", valid_even, 0);
    chk("rst_regwr_even", reg_write_even, 0);
    #1;
    reset = 1'b0;
    model_reset();
    put_pair(mkw(3, 6, 5, 0, 0), 0, FMT_RI10, 1, 1, mkw(7, 0, 0, 0, 0), 1, FMT_NOP, 0, 1);
    repeat (2) step();
    chk("rst_cnt5_cleared", valid_even, 1);
    idle(16);

    // Independent pair dual-issues one cycle after accept.
    wa = mkw(0, 3, 1, 2, 0);
    wb = mkw(3, 4, 6, 0, 0);
    put_pair(wa, 0, FMT_RR, 1, 2, wb, 1, FMT_RI10, 1, 2);
    step();
    chk("ind_accept_edge_valid", valid_even, 0);
    step();
    chk("ind_valid_even", valid_even, 1);
    chk("ind_valid_odd", valid_odd, 1);
    chk("ind_rt_even", rt_addr_even, 3);
    chk("ind_rt_odd", rt_addr_odd, 4);
    chk("ind_instr_even", instr_even, wa);
    chk("ind_instr_odd", instr_odd, wb);
    idle(16);

    // Same-pipe pair issues serially on the even pipe.
    wa = mkw(4, 7, 0, 0, 0);
    wb = mkw(4, 8, 0, 0, 0);
    put_pair(wa, 0, FMT_RI16, 1, 1, wb, 0, FMT_RI16, 1, 1);
    repeat (2) step();
    chk("same_c1_instr_even", instr_even, wa);
    chk("same_c1_instr_odd", instr_odd, NOP_ODD);
    chk("same_c1_valid_odd", valid_odd, 0);
    chk("same_c1_pair_ready", pair_ready, 0);
    step();
    chk("same_c2_instr_even", instr_even, wb);
    chk("same_c2_valid_even", valid_even, 1);
    chk("same_c3_pair_ready", pair_ready, 1);
    idle(16);

    // Intra-pair RAW: b waits for counter[10] 2 -> 1 -> 0.
    put_pair(mkw(4, 10, 0, 0, 0), 0, FMT_RI16, 1, 2, mkw(3, 11, 10, 0, 0), 1, FMT_RI10, 1, 1);
    repeat (2) step();
    chk("raw_e1_valid_even", valid_even, 1);
    chk("raw_e1_valid_odd", valid_odd, 0);
    step();
    chk("raw_e2_valid_odd", valid_odd, 0);
    step();
    chk("raw_e3_valid_odd", valid_odd, 0);
    step();
    chk("raw_e4_valid_odd", valid_odd, 1);
    chk("raw_e4_rt_odd", rt_addr_odd, 11);
    idle(16);

    // RRR destination in [4:10]; later pair reading rc=20 waits out lat=4.
    put_pair(mkw(1, 20, 1, 2, 3), 0, FMT_RRR, 1, 4, mkw(7, 0, 0, 0, 0), 1, FMT_NOP, 0, 1);
    repeat (2) step();
    chk("rrr_rt_even", rt_addr_even, 20);
    chk("rrr_format_even", format_even, FMT_RRR);
    put_pair(mkw(1, 21, 4, 5, 20), 0, FMT_RRR, 1, 1, mkw(7, 0, 0, 0, 0), 1, FMT_NOP, 0, 1);
    repeat (3) step();
    chk("rrr_wait_valid_even", valid_even, 0);
    step();
    chk("rrr_go_valid_even", valid_even, 1);
    chk("rrr_go_rt_even", rt_addr_even, 21);
    idle(16);

    // Flush while b is blocked; counter[12] keeps draining.
    put_pair(mkw(4, 12, 0, 0, 0), 0, FMT_RI16, 1, 6, mkw(3, 13, 12, 0, 0), 1, FMT_RI10, 1, 1);
    repeat (2) step();
    chk("fl_e1_valid_even", valid_even, 1);
    d_flush = 1;
    step();
    chk("fl_pair_ready_during", pair_ready, 0);
    d_flush = 0;
    step();
    chk("fl_valid_even", valid_even, 0);
    chk("fl_valid_odd", valid_odd, 0);
    chk("fl_instr_odd", instr_odd, NOP_ODD);
    chk("fl_pair_ready_after", pair_ready, 1);
    put_pair(mkw(3, 14, 12, 0, 0), 0, FMT_RI10, 1, 1, mkw(7, 0, 0, 0, 0), 1, FMT_NOP, 0, 1);
    repeat (3) step();
    chk("fl_cnt_wait", valid_even, 0);
    step();
    chk("fl_cnt_done", valid_even, 1);
    idle(16);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rand_ins(d_ia, d_pa, d_fa, d_wa, d_la);
      rand_ins(d_ib, d_pb, d_fb, d_wb, d_lb);
      d_pv    = ($urandom_range(0, 3) != 0);
      d_stall = ($urandom_range(0, 7) == 0);
      d_flush = ($urandom_range(0, 24) == 0);
      d_rst   = (i == 2000);
      step();
    end
    d_rst = 0;
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
